// File: rtl/otter_mem_arbiter_pkg.sv
// Shared types for the OTTER memory-port arbiter: response owner tags and access sizes.
package otter_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int unsigned STREAK_W = 4;

  // Tag pushed into the response pipe for the access issued this cycle.
  function automatic owner_t issue_owner(logic if_gnt, logic dm_gnt, logic dm_we);
    owner_t own;
    own = OWN_NONE;
    if (if_gnt)                own = OWN_IF;
    else if (dm_gnt && !dm_we) own = OWN_DM;
    return own;
  endfunction

endpackage

// File: rtl/otter_mem_arbiter_if.sv
// Bus bundle between the IF/DM requesters, the arbiter and the shared memory port.
interface otter_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              IF_REQ;
  logic [ADDR_W-1:0] IF_ADDR;
  logic              IF_GNT;
  logic              IF_RVALID;
  logic [31:0]       IF_RDATA;

  logic              DM_REQ;
  logic              DM_WE;
  logic [ADDR_W-1:0] DM_ADDR;
  logic [31:0]       DM_WDATA;
  logic [1:0]        DM_SIZE;
  logic              DM_SIGN;
  logic              DM_GNT;
  logic              DM_RVALID;
  logic [31:0]       DM_RDATA;

  logic              MEM_EN;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [31:0]       MEM_WDATA;
  logic [1:0]        MEM_SIZE;
  logic              MEM_SIGN;
  logic [31:0]       MEM_RDATA;

  // Arbiter side.
  modport slave (
    input  IF_REQ, IF_ADDR,
    output IF_GNT, IF_RVALID, IF_RDATA,
    input  DM_REQ, DM_WE, DM_ADDR, DM_WDATA, DM_SIZE, DM_SIGN,
    output DM_GNT, DM_RVALID, DM_RDATA,
    output MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_SIZE, MEM_SIGN,
    input  MEM_RDATA
  );

  // Requester / memory side.
  modport master (
    output IF_REQ, IF_ADDR,
    input  IF_GNT, IF_RVALID, IF_RDATA,
    output DM_REQ, DM_WE, DM_ADDR, DM_WDATA, DM_SIZE, DM_SIGN,
    input  DM_GNT, DM_RVALID, DM_RDATA,
    input  MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_SIZE, MEM_SIGN,
    output MEM_RDATA
  );

endinterface

// File: rtl/otter_mem_arbiter_rsp_tag_pipe.sv
// LATENCY-deep delay line of owner tags; the output tag names who owns MEM_RDATA this cycle.
module otter_rsp_tag_pipe
  import otter_mem_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  owner_t i_tag,
  output owner_t o_tag
);

  owner_t r_pipe [LATENCY];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < LATENCY; k++) begin
        r_pipe[k] <= OWN_NONE;
      end
    end else begin
      r_pipe[0] <= i_tag;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
    end
  end

  assign o_tag = r_pipe[LATENCY-1];

endmodule

// File: rtl/otter_mem_arbiter.sv
// Shares one memory port between instruction fetch and data memory; DM wins conflicts
// until IF has lost MAX_STREAK in a row. Read data is routed back by a delayed owner tag.
module otter_mem_arbiter
  import otter_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned MAX_STREAK = 4
) (
  input logic                CLK,
  input logic                RST_N,
  otter_mem_arbiter_if.slave bus
);

  logic [STREAK_W-1:0] r_streak;
  logic [STREAK_W-1:0] w_streak_nxt;
  logic                w_streak_full;
  logic                w_if_gnt;
  logic                w_dm_gnt;

  logic                w_mem_en;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [31:0]         w_mem_wdata;
  logic [1:0]          w_mem_size;
  logic                w_mem_sign;

  owner_t              w_push_tag;
  owner_t              w_rsp_tag;

  assign w_streak_full = (r_streak == STREAK_W'(MAX_STREAK));

  // Grants are qualified by RST_N so every output reads 0 while reset is held.
  always_comb begin
    w_dm_gnt = 1'b0;
    w_if_gnt = 1'b0;
    if (RST_N) begin
      w_dm_gnt = bus.DM_REQ && !(bus.IF_REQ && w_streak_full);
      w_if_gnt = bus.IF_REQ && !w_dm_gnt;
    end
  end

  always_comb begin
    w_streak_nxt = r_streak;
    if (!bus.IF_REQ || w_if_gnt) begin
      w_streak_nxt = '0;
    end else if (w_dm_gnt && !w_streak_full) begin
      w_streak_nxt = r_streak + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_streak <= '0;
    end else begin
      r_streak <= w_streak_nxt;
    end
  end

  always_comb begin
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_mem_size  = SIZE_BYTE;
    w_mem_sign  = 1'b0;
    if (w_dm_gnt) begin
      w_mem_en    = 1'b1;
      w_mem_we    = bus.DM_WE;
      w_mem_addr  = bus.DM_ADDR;
      w_mem_wdata = bus.DM_WDATA;
      w_mem_size  = bus.DM_SIZE;
      w_mem_sign  = bus.DM_SIGN;
    end else if (w_if_gnt) begin
      w_mem_en    = 1'b1;
      w_mem_addr  = bus.IF_ADDR;
      w_mem_size  = SIZE_WORD;
    end
  end

  assign bus.IF_GNT    = w_if_gnt;
  assign bus.DM_GNT    = w_dm_gnt;
  assign bus.MEM_EN    = w_mem_en;
  assign bus.MEM_WE    = w_mem_we;
  assign bus.MEM_ADDR  = w_mem_addr;
  assign bus.MEM_WDATA = w_mem_wdata;
  assign bus.MEM_SIZE  = w_mem_size;
  assign bus.MEM_SIGN  = w_mem_sign;

  assign w_push_tag = issue_owner(w_if_gnt, w_dm_gnt, bus.DM_WE);

  otter_rsp_tag_pipe #(
    .LATENCY (LATENCY)
  ) u_tag_pipe (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_tag   (w_push_tag),
    .o_tag   (w_rsp_tag)
  );

  always_comb begin
    bus.IF_RVALID = 1'b0;
    bus.IF_RDATA  = '0;
    bus.DM_RVALID = 1'b0;
    bus.DM_RDATA  = '0;
    if (w_rsp_tag == OWN_IF) begin
      bus.IF_RVALID = 1'b1;
      bus.IF_RDATA  = bus.MEM_RDATA;
    end else if (w_rsp_tag == OWN_DM) begin
      bus.DM_RVALID = 1'b1;
      bus.DM_RDATA  = bus.MEM_RDATA;
    end
  end

endmodule
